// File: rtl/hist_rmw_engine.sv
// ============================================================================
// Module   : hist_rmw_engine
// Function : Histogram read-modify-write engine for an async SRAM, with
//            saturating bin increments, a one-entry pending slot and a clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hist_rmw_engine #(
    parameter int AW       = 20,
    parameter int DW       = 16,
    parameter int RD_WAIT  = 2,
    parameter int WE_WIDTH = 2,
    parameter int CLR_LAST = 1023
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          BIN_VALID,
    input  logic [AW-1:0] BIN_ADR,
    output logic          BIN_READY,
    input  logic          CLR_START,
    output logic          CLR_BUSY,
    output logic          BIN_DONE,
    output logic [AW-1:0] ADX,
    input  logic [DW-1:0] DQ_IN,
    output logic [DW-1:0] DQ_OUT,
    output logic          DQ_OE,
    output logic          OEN,
    output logic          WEN,
    output logic [23:0]   EVT_CNT,
    output logic [15:0]   OVF_CNT
);

    localparam logic [3:0]    c_rd_load = 4'(RD_WAIT - 1);
    localparam logic [3:0]    c_we_load = 4'(WE_WIDTH - 1);
    localparam logic [AW-1:0] c_clr_last = AW'(CLR_LAST);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WS   = 3'd2,
        S_WE   = 3'd3,
        S_WH   = 3'd4,
        S_CS   = 3'd5,
        S_CE   = 3'd6,
        S_CH   = 3'd7
    } state_t;

    state_t        r_state;
    logic          r_slot_full;
    logic [AW-1:0] r_slot_adr;
    logic          r_clr_req;
    logic [3:0]    r_cnt;

    logic          w_accept;
    logic          w_pull;
    logic          w_sweep;
    logic          w_sweep_end;
    logic          w_slot_full_nxt;
    logic          w_clr_req_nxt;
    logic          w_sat;
    logic [DW-1:0] w_dq_inc;

    assign w_accept    = BIN_VALID & BIN_READY;
    // A pending bin always runs before a requested sweep, so it gets cleared too.
    assign w_pull      = r_slot_full & ((r_state == S_IDLE) | (r_state == S_WH));
    assign w_sweep     = (r_state == S_CS) | (r_state == S_CE) | (r_state == S_CH);
    assign w_sweep_end = (r_state == S_CH) & (ADX == c_clr_last);

    assign w_slot_full_nxt = w_accept ? 1'b1 : (w_pull ? 1'b0 : r_slot_full);
    assign w_clr_req_nxt   = w_sweep ? ~w_sweep_end : (r_clr_req | CLR_START);

    assign w_sat    = &DQ_IN;
    assign w_dq_inc = w_sat ? DQ_IN : DQ_IN + 1'b1;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= S_IDLE;
            r_slot_full <= 1'b0;
            r_slot_adr  <= '0;
            r_clr_req   <= 1'b0;
            r_cnt       <= '0;
            BIN_READY   <= 1'b0;
            CLR_BUSY    <= 1'b0;
            BIN_DONE    <= 1'b0;
            ADX         <= '0;
            DQ_OUT      <= '0;
            DQ_OE       <= 1'b0;
            OEN         <= 1'b1;
            WEN         <= 1'b1;
            EVT_CNT     <= '0;
            OVF_CNT     <= '0;
        end else begin
            r_slot_full <= w_slot_full_nxt;
            r_clr_req   <= w_clr_req_nxt;
            BIN_READY   <= ~w_slot_full_nxt & ~w_clr_req_nxt;
            BIN_DONE    <= 1'b0;
            if (w_accept) begin
                r_slot_adr <= BIN_ADR;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_slot_full) begin
                        r_state <= S_RD;
                        ADX     <= r_slot_adr;
                        OEN     <= 1'b0;
                        DQ_OE   <= 1'b0;
                        r_cnt   <= c_rd_load;
                    end else if (r_clr_req) begin
                        r_state  <= S_CS;
                        CLR_BUSY <= 1'b1;
                        EVT_CNT  <= '0;
                        OVF_CNT  <= '0;
                        ADX      <= '0;
                        DQ_OUT   <= '0;
                        DQ_OE    <= 1'b1;
                    end
                end
                S_RD: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_WS;
                        OEN     <= 1'b1;
                        DQ_OE   <= 1'b1;
                        DQ_OUT  <= w_dq_inc;
                        if (w_sat && (OVF_CNT != 16'hFFFF)) begin
                            OVF_CNT <= OVF_CNT + 16'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_WS: begin
                    r_state <= S_WE;
                    WEN     <= 1'b0;
                    r_cnt   <= c_we_load;
                end
                S_WE: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= S_WH;
                        WEN      <= 1'b1;
                        BIN_DONE <= 1'b1;
                        EVT_CNT  <= EVT_CNT + 24'd1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_WH: begin
                    if (r_slot_full) begin
                        r_state <= S_RD;
                        ADX     <= r_slot_adr;
                        OEN     <= 1'b0;
                        DQ_OE   <= 1'b0;
                        r_cnt   <= c_rd_load;
                    end else if (r_clr_req) begin
                        r_state  <= S_CS;
                        CLR_BUSY <= 1'b1;
                        EVT_CNT  <= '0;
                        OVF_CNT  <= '0;
                        ADX      <= '0;
                        DQ_OUT   <= '0;
                        DQ_OE    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        DQ_OE   <= 1'b0;
                    end
                end
                S_CS: begin
                    r_state <= S_CE;
                    WEN     <= 1'b0;
                    r_cnt   <= c_we_load;
                end
                S_CE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_CH;
                        WEN     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_CH: begin
                    if (w_sweep_end) begin
                        r_state  <= S_IDLE;
                        CLR_BUSY <= 1'b0;
                        DQ_OE    <= 1'b0;
                    end else begin
                        r_state <= S_CS;
                        ADX     <= ADX + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hist_rmw_engine.sv
// ============================================================================
// Module   : tb_hist_rmw_engine
// Function : Directed bench for hist_rmw_engine with a behavioural async SRAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hist_rmw_engine;

    localparam int AW = 20;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          BIN_VALID = 1'b0;
    logic [AW-1:0] BIN_ADR = '0;
    logic          CLR_START = 1'b0;
    logic          BIN_READY, CLR_BUSY, BIN_DONE, DQ_OE, OEN, WEN;
    logic [AW-1:0] ADX;
    logic [DW-1:0] DQ_IN, DQ_OUT;
    logic [23:0]   EVT_CNT;
    logic [15:0]   OVF_CNT;

    hist_rmw_engine #(
        .AW(AW), .DW(DW), .RD_WAIT(2), .WE_WIDTH(2), .CLR_LAST(15)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .BIN_VALID(BIN_VALID), .BIN_ADR(BIN_ADR),
        .BIN_READY(BIN_READY), .CLR_START(CLR_START), .CLR_BUSY(CLR_BUSY),
        .BIN_DONE(BIN_DONE), .ADX(ADX), .DQ_IN(DQ_IN), .DQ_OUT(DQ_OUT),
        .DQ_OE(DQ_OE), .OEN(OEN), .WEN(WEN), .EVT_CNT(EVT_CNT), .OVF_CNT(OVF_CNT)
    );

    always #4 CLK = ~CLK;

    logic [15:0] mem [0:1023];
    assign DQ_IN = (!OEN) ? mem[ADX[9:0]] : 16'hDEAD;

    int            total = 0;
    int            bad = 0;
    logic          prev_wen = 1'b1;
    logic [AW-1:0] lat_adx = '0;
    logic [15:0]   lat_dq = '0;

    typedef struct {
        logic [AW-1:0] adr;
        logic          preset;
        logic [15:0]   init;
        logic [15:0]   exp_word;
        logic [23:0]   exp_evt;
        logic [15:0]   exp_ovf;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge, apply SRAM writes and check the strobe protocol.
    task automatic tick();
        @(negedge CLK);
        if (!RSTN) begin
            prev_wen = 1'b1;
        end else begin
            if (!prev_wen && WEN) mem[lat_adx[9:0]] = lat_dq;
            chk("oen_wen_overlap", 32'(!OEN && !WEN), 32'd0);
            if (!WEN) begin
                if (prev_wen) begin
                    lat_adx = ADX;
                    lat_dq  = DQ_OUT;
                end else begin
                    chk("adx_stable_we", 32'(ADX), 32'(lat_adx));
                    chk("dq_stable_we", 32'(DQ_OUT), 32'(lat_dq));
                end
                chk("dq_oe_in_we", 32'(DQ_OE), 32'd1);
            end
            prev_wen = WEN;
        end
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        BIN_VALID = 1'b0;
        CLR_START = 1'b0;
        repeat (3) tick();
        RSTN = 1'b1;
        tick();
    endtask

    task automatic send_bin(input logic [AW-1:0] adr);
        int n = 0;
        while (!BIN_READY && n < 200) begin
            tick();
            n++;
        end
        chk("ready_timeout", 32'(n < 200), 32'd1);
        BIN_VALID = 1'b1;
        BIN_ADR = adr;
        @(posedge CLK);
        #1 BIN_VALID = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!BIN_DONE && n < 50);
        chk("done_timeout", 32'(BIN_DONE), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        vecs[0] = '{20'h00004, 1'b1, 16'hFFFF, 16'hFFFF, 24'd1, 16'd1};
        vecs[1] = '{20'h003FF, 1'b1, 16'h0000, 16'h0001, 24'd2, 16'd1};
        vecs[2] = '{20'h00020, 1'b1, 16'h00FE, 16'h00FF, 24'd3, 16'd1};
        vecs[3] = '{20'h00005, 1'b1, 16'hFFFE, 16'hFFFF, 24'd4, 16'd1};
        vecs[4] = '{20'h00005, 1'b0, 16'h0000, 16'hFFFF, 24'd5, 16'd2};
        vecs[5] = '{20'h00001, 1'b1, 16'h7FFF, 16'h8000, 24'd6, 16'd2};

        // Reset values
        RSTN = 1'b0;
        repeat (2) tick();
        chk("rst_adx", 32'(ADX), 32'd0);
        chk("rst_dq_out", 32'(DQ_OUT), 32'd0);
        chk("rst_strobes", 32'({DQ_OE, OEN, WEN}), 32'b011);
        chk("rst_flags", 32'({BIN_READY, CLR_BUSY, BIN_DONE}), 32'd0);
        chk("rst_evt", 32'(EVT_CNT), 32'd0);
        chk("rst_ovf", 32'(OVF_CNT), 32'd0);
        RSTN = 1'b1;
        #1 chk("ready_before_edge", 32'(BIN_READY), 32'd0);
        tick();
        chk("ready_after_reset", 32'(BIN_READY), 32'd1);

        // Single bin with cycle-level timing
        begin
            int oen_first = -1, oen_cnt = 0, wen_cnt = 0, done_c = -1;
            logic [AW-1:0] adx_rd = '0;
            logic [15:0]   dq_we = '0;
            mem[12'h123] = 16'd5;
            send_bin(20'h00123);
            for (int c = 0; c < 10; c++) begin
                tick();
                if (!OEN) begin
                    oen_cnt++;
                    if (oen_first < 0) oen_first = c;
                    adx_rd = ADX;
                end
                if (!WEN) begin
                    wen_cnt++;
                    dq_we = DQ_OUT;
                end
                if (BIN_DONE) done_c = c;
            end
            chk("single_oen_start", 32'(oen_first), 32'd1);
            chk("single_oen_len", 32'(oen_cnt), 32'd2);
            chk("single_rd_adx", 32'(adx_rd), 32'h123);
            chk("single_wen_len", 32'(wen_cnt), 32'd2);
            chk("single_wr_data", 32'(dq_we), 32'd6);
            chk("single_done_cycle", 32'(done_c), 32'd6);
            chk("single_mem", 32'(mem[12'h123]), 32'd6);
            chk("single_evt", 32'(EVT_CNT), 32'd1);
        end

        // Back-to-back bins 7, 7, 9 with BIN_VALID held
        do_reset();
        begin
            logic [AW-1:0] adrs [3];
            int idx = 0, done = 0, rdy_low = 0, c_first = -1, c_last = -1;
            adrs[0] = 20'd7; adrs[1] = 20'd7; adrs[2] = 20'd9;
            mem[7] = 16'd0;
            mem[9] = 16'd0;
            for (int c = 0; c < 60; c++) begin
                tick();
                if (!BIN_READY) rdy_low++;
                if (!OEN && c_first < 0) c_first = c;
                if (BIN_DONE) begin
                    done++;
                    if (done == 3) c_last = c;
                end
                if (done == 3) break;
                if (idx < 3) begin
                    BIN_VALID = 1'b1;
                    BIN_ADR = adrs[idx];
                    if (BIN_READY) idx++;
                end else begin
                    BIN_VALID = 1'b0;
                end
            end
            BIN_VALID = 1'b0;
            chk("b2b_done_count", 32'(done), 32'd3);
            chk("b2b_first_rd", 32'(c_first), 32'd2);
            chk("b2b_no_gap", 32'(c_last - c_first), 32'd17);
            chk("b2b_ready_low", 32'(rdy_low), 32'd11);
            chk("b2b_mem7", 32'(mem[7]), 32'd2);
            chk("b2b_mem9", 32'(mem[9]), 32'd1);
            chk("b2b_evt", 32'(EVT_CNT), 32'd3);
        end

        // Table: saturation and ordinary increments
        do_reset();
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].preset) mem[vecs[v].adr[9:0]] = vecs[v].init;
            send_bin(vecs[v].adr);
            wait_done();
            chk($sformatf("vec%0d_word", v), 32'(mem[vecs[v].adr[9:0]]), 32'(vecs[v].exp_word));
            chk($sformatf("vec%0d_evt", v), 32'(EVT_CNT), 32'(vecs[v].exp_evt));
            chk($sformatf("vec%0d_ovf", v), 32'(OVF_CNT), 32'(vecs[v].exp_ovf));
        end

        // Clear requested one cycle after bin 3 is accepted
        do_reset();
        begin
            int done = 0, busy = 0, wins = 0, nz_dq = 0, rdy_bad = 0, nz_mem = 0;
            logic seen_busy = 1'b0, my_prev = 1'b1;
            for (int i = 0; i < 16; i++) mem[i] = 16'h0100 + 16'(i);
            mem[3] = 16'h0010;
            mem[32] = 16'h0055;
            send_bin(20'd3);
            tick();
            CLR_START = 1'b1;
            tick();
            CLR_START = 1'b0;
            chk("clr_ready_drop", 32'(BIN_READY), 32'd0);
            for (int c = 0; c < 400; c++) begin
                tick();
                if (BIN_DONE) done++;
                if (CLR_BUSY) begin
                    seen_busy = 1'b1;
                    busy++;
                    if (BIN_READY) rdy_bad++;
                    if (!WEN && my_prev) wins++;
                    if (!WEN && DQ_OUT != 16'd0) nz_dq++;
                end else if (seen_busy) begin
                    break;
                end
                my_prev = WEN;
            end
            for (int i = 0; i < 16; i++) if (mem[i] != 16'd0) nz_mem++;
            chk("clr_bin_done", 32'(done), 32'd1);
            chk("clr_busy_cycles", 32'(busy), 32'd64);
            chk("clr_write_count", 32'(wins), 32'd16);
            chk("clr_write_zero", 32'(nz_dq), 32'd0);
            chk("clr_ready_in_sweep", 32'(rdy_bad), 32'd0);
            chk("clr_ready_back", 32'(BIN_READY), 32'd1);
            chk("clr_evt", 32'(EVT_CNT), 32'd0);
            chk("clr_ovf", 32'(OVF_CNT), 32'd0);
            chk("clr_mem_zero", 32'(nz_mem), 32'd0);
            chk("clr_mem_beyond", 32'(mem[32]), 32'h55);
        end

        // Reset asserted while WEN is low
        begin
            int n = 0;
            send_bin(20'd8);
            wait_done();
            chk("rstw_evt_before", 32'(EVT_CNT), 32'd1);
            send_bin(20'd8);
            do begin
                tick();
                n++;
            end while (WEN && n < 50);
            chk("rstw_reach_we", 32'(WEN), 32'd0);
            #1 RSTN = 1'b0;
            #1;
            chk("rstw_strobes", 32'({DQ_OE, OEN, WEN}), 32'b011);
            chk("rstw_counters", 32'({EVT_CNT, 8'(OVF_CNT)}), 32'd0);
            chk("rstw_ready", 32'(BIN_READY), 32'd0);
            tick();
            RSTN = 1'b1;
            #1 chk("rstw_ready_pre_edge", 32'(BIN_READY), 32'd0);
            tick();
            chk("rstw_ready_post_edge", 32'(BIN_READY), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
